// File: rtl/ex_mdu_pkg.sv
// Shared opcode/func constants, FSM state encoding and operand-sign decode
// for the EX-stage multiply/divide unit.
package ex_mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] ITER_LOAD = 5'd31;
  localparam logic [XLEN-1:0]  XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [6:0] EXE_OP_OP        = 7'b0110011;
  localparam logic [6:0] EXE_FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] EXE_FUNC3_MUL    = 3'b000;
  localparam logic [2:0] EXE_FUNC3_MULH   = 3'b001;
  localparam logic [2:0] EXE_FUNC3_MULHSU = 3'b010;
  localparam logic [2:0] EXE_FUNC3_MULHU  = 3'b011;
  localparam logic [2:0] EXE_FUNC3_DIV    = 3'b100;
  localparam logic [2:0] EXE_FUNC3_DIVU   = 3'b101;
  localparam logic [2:0] EXE_FUNC3_REM    = 3'b110;
  localparam logic [2:0] EXE_FUNC3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == EXE_FUNC3_MULH) || (f3 == EXE_FUNC3_MULHSU) ||
           (f3 == EXE_FUNC3_DIV)  || (f3 == EXE_FUNC3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == EXE_FUNC3_MULH) || (f3 == EXE_FUNC3_DIV) || (f3 == EXE_FUNC3_REM);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider datapath: 33-bit partial remainder and a quotient shift
// register that takes in one quotient bit per step.
module mdu_div_iter
  import ex_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN+1:0] shifted, diff;
  logic            ge;

  // One extra bit above the remainder so the borrow of the trial subtract is explicit.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {2'b00, dvsr_q};
  assign ge      = ~diff[XLEN+1];
  assign rem_d   = ge ? diff[XLEN:0] : shifted[XLEN:0];
  assign quo_d   = {quo_q[XLEN-2:0], ge};

  assign quo_nxt_o = quo_d;
  assign rem_nxt_o = rem_d[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit in EX; stalls the pipeline while it
// iterates one bit per cycle and presents a registered one-shot result.
//   state | meaning
//   IDLE  | waiting for an M-op on ID/EX
//   MUL   | shift-add multiply, 32 iterations
//   DIV   | restoring divide, 32 iterations
//   DONE  | result valid, held while stall_in
module ex_mdu
  import ex_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_func3,
  input  logic [6:0]      ex_func7,
  input  logic [XLEN-1:0] ex_reg1,
  input  logic [XLEN-1:0] ex_reg2,
  input  logic [4:0]      ex_wd,
  input  logic            ex_wreg,
  input  logic            stall_in,
  input  logic            flush,
  output logic            stallreq,
  output logic            mdu_valid,
  output logic [XLEN-1:0] mdu_result,
  output logic [4:0]      mdu_wd,
  output logic            mdu_wreg
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              mop, accept, last_iter;
  logic              s1, s2, neg_in;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_ovf, div_fast;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   mul_res, div_res;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;

  assign mop       = (ex_opcode == EXE_OP_OP) && (ex_func7 == EXE_FUNC7_MULDIV);
  assign accept    = (state_q == MDU_IDLE) && mop && !flush;
  assign last_iter = (cnt_q == '0);

  assign s1   = rs1_signed(ex_func3) & ex_reg1[XLEN-1];
  assign s2   = rs2_signed(ex_func3) & ex_reg2[XLEN-1];
  assign mag1 = s1 ? -ex_reg1 : ex_reg1;
  assign mag2 = s2 ? -ex_reg2 : ex_reg2;

  // Remainder takes the dividend sign; product and quotient take s1^s2.
  assign neg_in = (ex_func3[2] && ex_func3[1]) ? s1 : (s1 ^ s2);

  assign div_ovf  = rs1_signed(ex_func3) && (ex_reg1 == XLEN_MIN) && (ex_reg2 == '1);
  assign div_fast = ex_func3[2] && ((ex_reg2 == '0) || div_ovf);

  always_comb begin
    fast_res = '0;
    if (ex_reg2 == '0) fast_res = ex_func3[1] ? ex_reg1 : '1;
    else               fast_res = ex_func3[1] ? '0 : XLEN_MIN;
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign prod_fix = neg_q ? -acc_step : acc_step;
  assign mul_res  = (f3_q == EXE_FUNC3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign div_res  = f3_q[1] ? (neg_q ? -rem_nxt : rem_nxt)
                            : (neg_q ? -quo_nxt : quo_nxt);

  mdu_div_iter u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept && ex_func3[2] && !div_fast),
    .step_i     (state_q == MDU_DIV),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    valid_d  = 1'b0;
    result_d = result_q;
    stallreq = 1'b0;

    case (state_q)
      MDU_IDLE: begin
        stallreq = accept;
        if (accept) begin
          f3_d   = ex_func3;
          wd_d   = ex_wd;
          wreg_d = ex_wreg;
          neg_d  = neg_in;
          cnt_d  = ITER_LOAD;
          if (ex_func3[2]) begin
            if (div_fast) begin
              state_d  = MDU_DONE;
              valid_d  = 1'b1;
              result_d = fast_res;
            end else begin
              state_d = MDU_DIV;
            end
          end else begin
            state_d  = MDU_MUL;
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, mag1};
            mplier_d = mag2;
          end
        end
      end
      MDU_MUL: begin
        stallreq = 1'b1;
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (last_iter) begin
          state_d  = MDU_DONE;
          valid_d  = 1'b1;
          result_d = mul_res;
          cnt_d    = '0;
        end
      end
      MDU_DIV: begin
        stallreq = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (last_iter) begin
          state_d  = MDU_DONE;
          valid_d  = 1'b1;
          result_d = div_res;
          cnt_d    = '0;
        end
      end
      MDU_DONE: begin
        if (stall_in) valid_d = 1'b1;
        else          state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase

    if (flush) begin
      state_d = MDU_IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign mdu_valid  = valid_q;
  assign mdu_result = result_q;
  assign mdu_wd     = wd_q;
  assign mdu_wreg   = wreg_q & valid_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: arithmetic reference model plus a cycle-level expectation
// of stall/valid timing, exercised with directed and random M-ops.
module tb_ex_mdu;

  localparam logic [6:0] OP_OP  = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_M   = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [6:0]  ex_func7;
  logic [31:0] ex_reg1, ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic        stall_in;
  logic        flush;
  logic        stallreq;
  logic        mdu_valid;
  logic [31:0] mdu_result;
  logic [4:0]  mdu_wd;
  logic        mdu_wreg;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_mdu dut (
    .clk        (clk),
    .rst        (rst),
    .ex_opcode  (ex_opcode),
    .ex_func3   (ex_func3),
    .ex_func7   (ex_func7),
    .ex_reg1    (ex_reg1),
    .ex_reg2    (ex_reg2),
    .ex_wd      (ex_wd),
    .ex_wreg    (ex_wreg),
    .stall_in   (stall_in),
    .flush      (flush),
    .stallreq   (stallreq),
    .mdu_valid  (mdu_valid),
    .mdu_result (mdu_result),
    .mdu_wd     (mdu_wd),
    .mdu_wreg   (mdu_wreg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M results straight from the ISA arithmetic rules.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: begin p = a * b; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Model: cycles elapsed since accept (-1 when idle); result due after m_len cycles.
  int          m_k = -1;
  int          m_len = 0;
  logic [31:0] m_res;
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic        e_stall, e_valid, mop_s;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        mop_s = (ex_opcode == OP_OP) && (ex_func7 == F7_M);
        if (m_k < 0) begin
          e_stall = mop_s && !flush;
          e_valid = 1'b0;
        end else if (m_k < m_len) begin
          e_stall = 1'b1;
          e_valid = 1'b0;
        end else begin
          e_stall = 1'b0;
          e_valid = 1'b1;
        end
        chk("stallreq", 32'(stallreq), 32'(e_stall));
        chk("mdu_valid", 32'(mdu_valid), 32'(e_valid));
        chk("mdu_wreg", 32'(mdu_wreg), 32'(e_valid & m_wreg));
        if (e_valid) begin
          chk("mdu_result", mdu_result, m_res);
          chk("mdu_wd", 32'(mdu_wd), 32'(m_wd));
        end
        if (rst || flush) m_k = -1;
        else if (m_k < 0) begin
          if (mop_s) begin
            m_k    = 1;
            m_len  = is_fast(ex_func3, ex_reg1, ex_reg2) ? 1 : 33;
            m_res  = ref_mdu(ex_func3, ex_reg1, ex_reg2);
            m_wd   = ex_wd;
            m_wreg = ex_wreg;
          end
        end else if (m_k < m_len) m_k++;
        else if (!stall_in) m_k = -1;
      end
    end
  end

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input logic wreg);
    ex_opcode = OP_OP;
    ex_func7  = F7_M;
    ex_func3  = f3;
    ex_reg1   = a;
    ex_reg2   = b;
    ex_wd     = wd;
    ex_wreg   = wreg;
  endtask

  task automatic drive_bubble(input logic add_form);
    ex_opcode = add_form ? OP_OP : OP_IMM;
    ex_func7  = 7'b0000000;
    ex_func3  = 3'($urandom_range(0, 7));
    ex_reg1   = $urandom();
    ex_reg2   = $urandom();
    ex_wd     = 5'($urandom_range(0, 31));
    ex_wreg   = 1'b1;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_bubble(1'($urandom_range(0, 1)));
    end
  endtask

  // Present an M-op as ID/EX would, hold it until DONE, then stall DONE nstall cycles.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wreg, input int nstall,
                       input logic do_lit, input logic [31:0] lit, input int lat);
    int cyc;
    @(posedge clk); #1;
    drive_op(f3, a, b, wd, wreg);
    stall_in = 1'b0;
    cyc = 0;
    while (!mdu_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 32'(mdu_valid), 32'd1);
    if (lat > 0) chk("latency", cyc, lat);
    if (do_lit) begin
      chk("lit_result", mdu_result, lit);
      chk("lit_wd", 32'(mdu_wd), 32'(wd));
      chk("lit_wreg", 32'(mdu_wreg), 32'(wreg));
    end
    for (int i = 0; i < nstall; i++) begin
      stall_in = 1'b1;
      @(posedge clk); #1;
    end
    stall_in = 1'b0;
  endtask

  task automatic kill_test(input logic use_rst);
    @(posedge clk); #1;
    drive_op(3'd4, 32'd1000, 32'd3, 5'd9, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    flush = 1'b0;
    drive_bubble(1'b0);
    #1;
    chk("kill_stallreq", 32'(stallreq), 32'd0);
    chk("kill_valid", 32'(mdu_valid), 32'd0);
    if (use_rst) begin
      chk("rst_result", mdu_result, 32'd0);
      chk("rst_wd", 32'(mdu_wd), 32'd0);
      chk("rst_wreg", 32'(mdu_wreg), 32'd0);
    end
    bubbles(40);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    rst      = 1'b1;
    stall_in = 1'b0;
    flush    = 1'b0;
    drive_bubble(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(mdu_valid), 32'd0);
    chk("reset_result", mdu_result, 32'd0);
    chk("reset_wd", 32'(mdu_wd), 32'd0);
    chk("reset_wreg", 32'(mdu_wreg), 32'd0);
    chk("reset_stallreq", 32'(stallreq), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 0, 1'b1, 32'hFFFF_FFEB, 33);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 0, 1'b1, 32'hFFFF_FFFE, 33);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0, 0, 1'b1, 32'h0000_0000, 33);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 33);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, 0, 1'b1, 32'h0000_0001, 33);
    issue(3'd4, -32'd7, 32'd2, 5'd8, 1'b1, 0, 1'b1, 32'hFFFF_FFFD, 33);
    issue(3'd6, -32'd7, 32'd2, 5'd9, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 33);
    issue(3'd5, 32'd100, 32'd7, 5'd10, 1'b1, 0, 1'b1, 32'd14, 33);
    issue(3'd7, 32'd100, 32'd7, 5'd11, 1'b1, 0, 1'b1, 32'd2, 33);
    bubbles(2);
    issue(3'd5, 32'd5, 32'd0, 5'd12, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 1);
    issue(3'd6, 32'd5, 32'd0, 5'd13, 1'b1, 0, 1'b1, 32'd5, 1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 0, 1'b1, 32'h8000_0000, 1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 0, 1'b1, 32'h0, 1);
    issue(3'd5, 32'd100, 32'd7, 5'd16, 1'b1, 3, 1'b1, 32'd14, 33);
    bubbles(3);

    @(posedge clk); #1;
    drive_bubble(1'b1);
    #1;
    chk("add_no_stall", 32'(stallreq), 32'd0);
    bubbles(3);

    kill_test(1'b0);
    kill_test(1'b1);

    for (int n = 0; n < 160; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      issue(rf3, ra, rb, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2), 1'b0, 32'h0, 0);
      if ($urandom_range(0, 3) == 0) bubbles($urandom_range(1, 3));
    end
    bubbles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
